// File: rtl/c3po_gearbox.sv
// c3po_gearbox: wide-to-narrow packet gearbox with per-packet port filtering.
//
// Each accepted input beat (IN_BYTES_P bytes) that belongs to a passing packet
// is registered and replayed as ceil(vbc/OUT_BYTES_P) output beats of
// OUT_BYTES_P bytes, starting the cycle after acceptance. Packets are passed
// when CTRL.port_enable is set and the sop id equals CFG.port_id. Otherwise
// they are dropped. Passed and dropped packets are counted in saturating
// counters. Config and counters are reachable over the c3po register interface.
//
// Optional build macro: C3PO_CNT_CLR_ON_READ_EN -- a register read of CNT0/CNT1
// clears that counter in the ack cycle (an increment in the same cycle leaves 1).
//
// Ports:
//   sig_clock, sig_reset        clock, synchronous active-high reset
//   sig_sop/eop/val/vbc/id/data input beat; sig_ready = beat accepted with val
//   sig_o_sop/eop/val/vbc/data  output beat (no backpressure)
//   sig_cnt0_val, sig_cnt1_val  passed / dropped packet counters
//   sig_cfg_port_id             CFG register, sig_ctrl_port_enable CTRL bit 0
//   sig_addr/req/rd_wr/write_val register request; sig_read_val/sig_ack reply
module c3po_gearbox #(
  parameter int IN_BYTES_P  = 160,
  parameter int OUT_BYTES_P = 32,
  parameter int VBC_W_P     = 8,
  parameter int ID_W_P      = 4,
  parameter int CNT_SIZE_P  = 8,
  parameter int ADDR_SIZE_P = 6
) (
  input  logic                     sig_clock,
  input  logic                     sig_reset,
  input  logic                     sig_sop,
  input  logic                     sig_eop,
  input  logic                     sig_val,
  input  logic [VBC_W_P-1:0]       sig_vbc,
  input  logic [ID_W_P-1:0]        sig_id,
  input  logic [IN_BYTES_P*8-1:0]  sig_data,
  output logic                     sig_ready,
  output logic                     sig_o_sop,
  output logic                     sig_o_eop,
  output logic                     sig_o_val,
  output logic [VBC_W_P-1:0]       sig_o_vbc,
  output logic [OUT_BYTES_P*8-1:0] sig_o_data,
  output logic [CNT_SIZE_P-1:0]    sig_cnt0_val,
  output logic [CNT_SIZE_P-1:0]    sig_cnt1_val,
  output logic [ID_W_P-1:0]        sig_cfg_port_id,
  output logic                     sig_ctrl_port_enable,
  input  logic [ADDR_SIZE_P-1:0]   sig_addr,
  input  logic                     sig_req,
  input  logic                     sig_rd_wr,
  input  logic [31:0]              sig_write_val,
  output logic [31:0]              sig_read_val,
  output logic                     sig_ack
);

  localparam int IN_W  = IN_BYTES_P * 8;
  localparam int OUT_W = OUT_BYTES_P * 8;
  localparam logic [VBC_W_P-1:0] OUT_BYTES_V = VBC_W_P'(OUT_BYTES_P);
  localparam logic [VBC_W_P-1:0] IN_BYTES_V  = VBC_W_P'(IN_BYTES_P);

  localparam logic [ADDR_SIZE_P-1:0] ADDR_CTRL   = ADDR_SIZE_P'(0);
  localparam logic [ADDR_SIZE_P-1:0] ADDR_CFG    = ADDR_SIZE_P'(1);
  localparam logic [ADDR_SIZE_P-1:0] ADDR_CNT0   = ADDR_SIZE_P'(2);
  localparam logic [ADDR_SIZE_P-1:0] ADDR_CNT1   = ADDR_SIZE_P'(3);
  localparam logic [ADDR_SIZE_P-1:0] ADDR_STATUS = ADDR_SIZE_P'(4);

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IN_W-1:0]       data_q, data_d;
  logic [VBC_W_P-1:0]    rem_q, rem_d;
  logic                  sop_q, sop_d, eop_q, eop_d;
  logic                  in_pkt_q, in_pkt_d, pass_q, pass_d;
  logic [CNT_SIZE_P-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic [ID_W_P-1:0]     cfg_id_q, cfg_id_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  last_beat, accept, beat_pass, beat_emit, pkt_end;
  logic                  reg_rd, reg_wr;
  logic [VBC_W_P-1:0]    vbc_in, out_vbc;
  logic                  unused_wr_bits;

  function automatic logic [CNT_SIZE_P-1:0] sat_inc(input logic [CNT_SIZE_P-1:0] v);
    return (&v) ? v : v + CNT_SIZE_P'(1);
  endfunction

  function automatic logic [VBC_W_P-1:0] clamp_bytes(input logic [VBC_W_P-1:0] v,
                                                      input logic [VBC_W_P-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign unused_wr_bits = ^sig_write_val;

  // Input acceptance and per-packet filter decision
  always_comb begin
    last_beat = (rem_q <= OUT_BYTES_V);
    accept    = sig_val && sig_ready;
    vbc_in    = clamp_bytes(sig_vbc, IN_BYTES_V);
    // sop takes a fresh decision; later beats inherit it only inside a packet
    beat_pass = sig_sop ? (ctrl_en_q && (sig_id == cfg_id_q)) : (in_pkt_q && pass_q);
    beat_emit = accept && beat_pass && (vbc_in != '0);
    pkt_end   = accept && sig_eop && (sig_sop || in_pkt_q);
    reg_rd    = sig_req && sig_rd_wr;
    reg_wr    = sig_req && !sig_rd_wr;
  end

  // Next-state / split datapath
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (state_q == SPLIT && !last_beat) begin
      data_d = data_q >> OUT_W;
      rem_d  = rem_q - OUT_BYTES_V;
      sop_d  = 1'b0;
    end else if (beat_emit) begin
      state_d = SPLIT;
      data_d  = sig_data;
      rem_d   = vbc_in;
      sop_d   = sig_sop;
      eop_d   = sig_eop;
    end else begin
      state_d = IDLE;
    end
  end

  // Packet tracking, counters and register file
  always_comb begin
    in_pkt_d  = in_pkt_q;
    pass_d    = pass_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    ctrl_en_d = ctrl_en_q;
    cfg_id_d  = cfg_id_q;
    ack_d     = sig_req;
    rdata_d   = '0;
    if (accept) begin
      if (sig_sop) begin
        pass_d   = beat_pass;
        in_pkt_d = !sig_eop;
      end else if (sig_eop) begin
        in_pkt_d = 1'b0;
      end
    end
    if (pkt_end && beat_pass)  cnt0_d = sat_inc(cnt0_q);
    if (pkt_end && !beat_pass) cnt1_d = sat_inc(cnt1_q);
    if (reg_wr) begin
      if (sig_addr == ADDR_CTRL) ctrl_en_d = sig_write_val[0];
      if (sig_addr == ADDR_CFG)  cfg_id_d  = sig_write_val[ID_W_P-1:0];
    end
    if (reg_rd) begin
      case (sig_addr)
        ADDR_CTRL:   rdata_d[0]   = ctrl_en_q;
        ADDR_CFG:    rdata_d      = 32'(cfg_id_q);
        ADDR_CNT0:   rdata_d      = 32'(cnt0_q);
        ADDR_CNT1:   rdata_d      = 32'(cnt1_q);
        ADDR_STATUS: rdata_d[1:0] = {in_pkt_q, state_q == SPLIT};
        default:     rdata_d      = '0;
      endcase
    end
`ifdef C3PO_CNT_CLR_ON_READ_EN
    if (reg_rd && sig_addr == ADDR_CNT0)
      cnt0_d = (pkt_end && beat_pass) ? CNT_SIZE_P'(1) : '0;
    if (reg_rd && sig_addr == ADDR_CNT1)
      cnt1_d = (pkt_end && !beat_pass) ? CNT_SIZE_P'(1) : '0;
`endif
  end

  // Control state register
  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      in_pkt_q  <= 1'b0;
      pass_q    <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      ctrl_en_q <= 1'b0;
      cfg_id_q  <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      in_pkt_q  <= in_pkt_d;
      pass_q    <= pass_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      ctrl_en_q <= ctrl_en_d;
      cfg_id_q  <= cfg_id_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  // Beat data register; outputs are gated by state so it needs no reset
  always_ff @(posedge sig_clock) begin
    data_q <= data_d;
  end

  // Outputs
  assign sig_ready = (state_q == IDLE) || last_beat;

  always_comb begin
    out_vbc    = clamp_bytes(rem_q, OUT_BYTES_V);
    sig_o_val  = (state_q == SPLIT);
    sig_o_sop  = (state_q == SPLIT) && sop_q;
    sig_o_eop  = (state_q == SPLIT) && eop_q && last_beat;
    sig_o_vbc  = (state_q == SPLIT) ? out_vbc : '0;
    sig_o_data = '0;
    if (state_q == SPLIT) begin
      for (int k = 0; k < OUT_BYTES_P; k++) begin
        if (VBC_W_P'(k) < out_vbc) sig_o_data[8*k +: 8] = data_q[8*k +: 8];
      end
    end
  end

  assign sig_cnt0_val         = cnt0_q;
  assign sig_cnt1_val         = cnt1_q;
  assign sig_cfg_port_id      = cfg_id_q;
  assign sig_ctrl_port_enable = ctrl_en_q;
  assign sig_read_val         = rdata_q;
  assign sig_ack              = ack_q;

endmodule

// File: tb/tb_c3po_gearbox.sv
module tb_c3po_gearbox;

  logic          sig_clock = 1'b0;
  logic          sig_reset;
  logic          sig_sop, sig_eop, sig_val;
  logic [7:0]    sig_vbc;
  logic [3:0]    sig_id;
  logic [1279:0] sig_data;
  logic          sig_ready;
  logic          sig_o_sop, sig_o_eop, sig_o_val;
  logic [7:0]    sig_o_vbc;
  logic [255:0]  sig_o_data;
  logic [7:0]    sig_cnt0_val, sig_cnt1_val;
  logic [3:0]    sig_cfg_port_id;
  logic          sig_ctrl_port_enable;
  logic [5:0]    sig_addr;
  logic          sig_req, sig_rd_wr;
  logic [31:0]   sig_write_val, sig_read_val;
  logic          sig_ack;

  int vectors = 0;
  int miscompares = 0;

  c3po_gearbox dut (
    .sig_clock(sig_clock), .sig_reset(sig_reset),
    .sig_sop(sig_sop), .sig_eop(sig_eop), .sig_val(sig_val), .sig_vbc(sig_vbc),
    .sig_id(sig_id), .sig_data(sig_data), .sig_ready(sig_ready),
    .sig_o_sop(sig_o_sop), .sig_o_eop(sig_o_eop), .sig_o_val(sig_o_val),
    .sig_o_vbc(sig_o_vbc), .sig_o_data(sig_o_data),
    .sig_cnt0_val(sig_cnt0_val), .sig_cnt1_val(sig_cnt1_val),
    .sig_cfg_port_id(sig_cfg_port_id), .sig_ctrl_port_enable(sig_ctrl_port_enable),
    .sig_addr(sig_addr), .sig_req(sig_req), .sig_rd_wr(sig_rd_wr),
    .sig_write_val(sig_write_val), .sig_read_val(sig_read_val), .sig_ack(sig_ack)
  );

  always #5 sig_clock = ~sig_clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sig_clock);
    #1;
  endtask

  function automatic logic [1279:0] fill(input int base);
    logic [1279:0] v;
    for (int k = 0; k < 160; k++) v[8*k +: 8] = 8'(base + k);
    return v;
  endfunction

  // Expected output beat j of an input filled from 'base', with nbytes valid
  function automatic logic [255:0] exp_beat(input int base, input int j, input int nbytes);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < nbytes; k++) v[8*k +: 8] = 8'(base + j*32 + k);
    return v;
  endfunction

  task automatic drive(input logic sop, input logic eop, input int vbc, input int id,
                       input logic [1279:0] d);
    sig_val  = 1'b1;
    sig_sop  = sop;
    sig_eop  = eop;
    sig_vbc  = 8'(vbc);
    sig_id   = 4'(id);
    sig_data = d;
  endtask

  task automatic idle_in();
    sig_val = 1'b0;
    sig_sop = 1'b0;
    sig_eop = 1'b0;
  endtask

  task automatic reg_wr(input int addr, input int val);
    sig_req       = 1'b1;
    sig_rd_wr     = 1'b0;
    sig_addr      = 6'(addr);
    sig_write_val = 32'(val);
    tick();
    sig_req = 1'b0;
    check("wr_ack", 256'(sig_ack), 256'(1));
    tick();
  endtask

  task automatic reg_rd(input string tag, input int addr, input int exp);
    sig_req   = 1'b1;
    sig_rd_wr = 1'b1;
    sig_addr  = 6'(addr);
    tick();
    sig_req = 1'b0;
    check({tag, "_ack"}, 256'(sig_ack), 256'(1));
    check(tag, 256'(sig_read_val), 256'(exp));
    tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_o_val"}, 256'(sig_o_val), 256'(0));
    check({tag, "_o_sop"}, 256'(sig_o_sop), 256'(0));
    check({tag, "_o_eop"}, 256'(sig_o_eop), 256'(0));
    check({tag, "_o_vbc"}, 256'(sig_o_vbc), 256'(0));
    check({tag, "_o_data"}, sig_o_data, 256'(0));
    check({tag, "_ready"}, 256'(sig_ready), 256'(1));
  endtask

  task automatic check_reset_state(input string tag);
    check_quiet(tag);
    check({tag, "_cnt0"}, 256'(sig_cnt0_val), 256'(0));
    check({tag, "_cnt1"}, 256'(sig_cnt1_val), 256'(0));
    check({tag, "_cfg"}, 256'(sig_cfg_port_id), 256'(0));
    check({tag, "_ctrl"}, 256'(sig_ctrl_port_enable), 256'(0));
    check({tag, "_rdval"}, 256'(sig_read_val), 256'(0));
    check({tag, "_ack"}, 256'(sig_ack), 256'(0));
  endtask

  initial begin
    sig_reset = 1'b1;
    idle_in();
    sig_vbc = '0; sig_id = '0; sig_data = '0;
    sig_addr = '0; sig_req = 1'b0; sig_rd_wr = 1'b0; sig_write_val = '0;
    tick();
    tick();
    check_reset_state("rst");
    sig_reset = 1'b0;
    tick();

    // Configure: enable, port id 3
    reg_wr(0, 1);
    reg_wr(1, 3);
    check("ctrl_en", 256'(sig_ctrl_port_enable), 256'(1));
    check("cfg_id", 256'(sig_cfg_port_id), 256'(3));

    // Full 160-byte single-beat packet -> 5 beats of 32
    drive(1'b1, 1'b1, 160, 3, fill(0));
    tick();
    idle_in();
    for (int j = 0; j < 5; j++) begin
      check("full_val", 256'(sig_o_val), 256'(1));
      check("full_vbc", 256'(sig_o_vbc), 256'(32));
      check("full_sop", 256'(sig_o_sop), 256'(j == 0));
      check("full_eop", 256'(sig_o_eop), 256'(j == 4));
      check("full_ready", 256'(sig_ready), 256'(j == 4));
      check("full_data", sig_o_data, exp_beat(0, j, 32));
      tick();
    end
    check("full_after_val", 256'(sig_o_val), 256'(0));
    check("full_cnt0", 256'(sig_cnt0_val), 256'(1));

    // vbc=70 (sop) then vbc=32 (eop) accepted on the last output beat
    drive(1'b1, 1'b0, 70, 3, fill(100));
    tick();
    idle_in();
    check("b2b0_vbc", 256'(sig_o_vbc), 256'(32));
    check("b2b0_sop", 256'(sig_o_sop), 256'(1));
    check("b2b0_ready", 256'(sig_ready), 256'(0));
    check("b2b0_data", sig_o_data, exp_beat(100, 0, 32));
    sig_req = 1'b1; sig_rd_wr = 1'b1; sig_addr = 6'd4;
    tick();
    sig_req = 1'b0;
    check("b2b1_vbc", 256'(sig_o_vbc), 256'(32));
    check("b2b1_sop", 256'(sig_o_sop), 256'(0));
    check("b2b1_data", sig_o_data, exp_beat(100, 1, 32));
    check("status_ack", 256'(sig_ack), 256'(1));
    check("status_split_inpkt", 256'(sig_read_val), 256'(3));
    tick();
    check("b2b2_vbc", 256'(sig_o_vbc), 256'(6));
    check("b2b2_ready", 256'(sig_ready), 256'(1));
    check("b2b2_eop", 256'(sig_o_eop), 256'(0));
    check("b2b2_data", sig_o_data, exp_beat(100, 2, 6));
    drive(1'b0, 1'b1, 32, 3, fill(192));
    tick();
    idle_in();
    check("b2b3_val", 256'(sig_o_val), 256'(1));
    check("b2b3_vbc", 256'(sig_o_vbc), 256'(32));
    check("b2b3_sop", 256'(sig_o_sop), 256'(0));
    check("b2b3_eop", 256'(sig_o_eop), 256'(1));
    check("b2b3_data", sig_o_data, exp_beat(192, 0, 32));
    tick();
    check("b2b_after_val", 256'(sig_o_val), 256'(0));
    check("b2b_cnt0", 256'(sig_cnt0_val), 256'(2));

    // Dropped 3-beat packet with id 5 (later beats carry id 3: decision holds)
    drive(1'b1, 1'b0, 160, 5, fill(7));
    tick();
    check("drop0_val", 256'(sig_o_val), 256'(0));
    check("drop0_ready", 256'(sig_ready), 256'(1));
    drive(1'b0, 1'b0, 160, 3, fill(8));
    tick();
    check("drop1_val", 256'(sig_o_val), 256'(0));
    check("drop1_ready", 256'(sig_ready), 256'(1));
    drive(1'b0, 1'b1, 160, 3, fill(9));
    tick();
    idle_in();
    check("drop2_val", 256'(sig_o_val), 256'(0));
    check("drop2_ready", 256'(sig_ready), 256'(1));
    check("drop_cnt1", 256'(sig_cnt1_val), 256'(1));
    check("drop_cnt0", 256'(sig_cnt0_val), 256'(2));

    // Saturation: 300 single-byte packets, one per cycle
    drive(1'b1, 1'b1, 1, 3, fill(0));
    for (int i = 0; i < 252; i++) tick();
    check("sat_mid_cnt0", 256'(sig_cnt0_val), 256'(254));
    check("sat_mid_val", 256'(sig_o_val), 256'(1));
    check("sat_mid_vbc", 256'(sig_o_vbc), 256'(1));
    check("sat_mid_data", sig_o_data, 256'(0));
    for (int i = 0; i < 48; i++) tick();
    check("sat_300_cnt0", 256'(sig_cnt0_val), 256'(255));
    tick();
    check("sat_301_cnt0", 256'(sig_cnt0_val), 256'(255));
    idle_in();
    tick();
    tick();

    // Back-to-back write then read of CFG
    sig_req = 1'b1; sig_rd_wr = 1'b0; sig_addr = 6'd1; sig_write_val = 32'hA;
    tick();
    check("bb_wr_ack", 256'(sig_ack), 256'(1));
    sig_rd_wr = 1'b1;
    tick();
    sig_req = 1'b0;
    check("bb_rd_ack", 256'(sig_ack), 256'(1));
    check("bb_rd_cfg", 256'(sig_read_val), 256'(10));
    tick();
    check("bb_idle_ack", 256'(sig_ack), 256'(0));
    check("bb_idle_rdval", 256'(sig_read_val), 256'(0));
    check("cfg_port", 256'(sig_cfg_port_id), 256'(10));
    reg_rd("rd_unmapped", 63, 0);
    reg_wr(2, 0);
    check("ro_cnt0", 256'(sig_cnt0_val), 256'(255));
    reg_rd("rd_cnt0", 2, 255);
    reg_rd("rd_cnt1", 3, 1);
    reg_rd("rd_ctrl", 0, 1);
    reg_rd("rd_status_idle", 4, 0);

    // Reset during beat 2 of a 5-beat split
    reg_wr(1, 3);
    drive(1'b1, 1'b1, 160, 3, fill(0));
    tick();
    idle_in();
    check("rs_b1_val", 256'(sig_o_val), 256'(1));
    tick();
    check("rs_b2_val", 256'(sig_o_val), 256'(1));
    check("rs_b2_data", sig_o_data, exp_beat(0, 1, 32));
    sig_reset = 1'b1;
    tick();
    check_reset_state("rs");
    sig_reset = 1'b0;
    tick();
    check_quiet("rs_post");
    tick();
    check("rs_post2_eop", 256'(sig_o_eop), 256'(0));
    reg_rd("rs_rd_ctrl", 0, 0);
    reg_rd("rs_rd_cfg", 1, 0);
    reg_rd("rs_rd_cnt0", 2, 0);
    reg_rd("rs_rd_cnt1", 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
